// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB4 register-bank slave interface.
// Contents: FSM state enum, error read pattern, bytes-per-word helper.
// Imported by apb_addr_decode and apb_slave_if_gen.
package apb_slave_pkg;

  // Transfer sequencing: IDLE -> ACCESS/ERROR -> DONE/ERROR -> IDLE
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERROR  = 2'd3
  } apb_state_t;

  // Read data returned with PSLVERR; replicated per 32-bit lane on wider buses
  localparam logic [31:0] ERR_DATA = 32'hBAD1BAD1;

  // Bytes per bus word
  function automatic int bpw(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational register address decoder for the APB slave interface.
// Ports: addr_i (PADDR[11:0]) in; match_o, one-hot sel_o and binary idx_o out.
// A register matches only on its exact word-aligned byte address; any nonzero
// sub-word address bits or an address past the last register gives no match.
module apb_addr_decode
  import apb_slave_pkg::*;
#(
  parameter int          NUM_REGS    = 8,
  parameter int          DATA_W      = 32,
  parameter logic [11:0] ADDR_OFFSET = 12'h000,
  parameter int          IDX_W       = $clog2(NUM_REGS)
) (
  input  logic [11:0]         addr_i,
  output logic                match_o,
  output logic [NUM_REGS-1:0] sel_o,
  output logic [IDX_W-1:0]    idx_o
);

  localparam int BPW   = bpw(DATA_W);
  localparam int LSB_W = $clog2(BPW);

  always_comb begin
    match_o = 1'b0;
    sel_o   = '0;
    idx_o   = '0;
    if (addr_i[LSB_W-1:0] == '0) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        // Registers whose address would fall beyond the 4 KB window never match
        if ((int'(ADDR_OFFSET) + i * BPW) < 4096) begin
          if (addr_i == 12'(int'(ADDR_OFFSET) + i * BPW)) begin
            match_o  = 1'b1;
            sel_o[i] = 1'b1;
            idx_o    = IDX_W'(i);
          end
        end
      end
    end
  end

endmodule

// File: rtl/apb_slave_if_gen.sv
// APB4 slave front-end for a peripheral register bank (timer, GPIO, UART, ...).
// Ports: APB4 slave side (PADDR..PSLVERR); register bank side read_data/reg_ready
// in, one-hot w_enable/r_enable plus latched w_data/w_strb out. All outputs are
// registered. Zero-wait bank gives PREADY in the 3rd cycle of a transfer; each
// low reg_ready cycle adds one, and MAX_WAIT stalled ACCESS cycles end in PSLVERR.
module apb_slave_if_gen
  import apb_slave_pkg::*;
#(
  parameter int                  NUM_REGS    = 8,
  parameter int                  DATA_W      = 32,
  parameter logic [11:0]         ADDR_OFFSET = 12'h000,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
  parameter logic [NUM_REGS-1:0] WO_MASK     = '0,
  parameter int                  MAX_WAIT    = 4
) (
  input  logic                             clk,
  input  logic                             n_rst,
  // APB4 slave
  input  logic [31:0]                      PADDR,
  input  logic [DATA_W-1:0]                PWDATA,
  input  logic [DATA_W/8-1:0]              PSTRB,
  input  logic                             PSEL,
  input  logic                             PENABLE,
  input  logic                             PWRITE,
  output logic [DATA_W-1:0]                PRDATA,
  output logic                             PREADY,
  output logic                             PSLVERR,
  // Register bank
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  read_data,
  input  logic                             reg_ready,
  output logic [NUM_REGS-1:0]              w_enable,
  output logic [NUM_REGS-1:0]              r_enable,
  output logic [DATA_W-1:0]                w_data,
  output logic [DATA_W/8-1:0]              w_strb
);

  localparam int                IDX_W    = $clog2(NUM_REGS);
  localparam int                WC_W     = $clog2(MAX_WAIT + 1);
  localparam logic [DATA_W-1:0] ERR_WORD = {(DATA_W / 32){ERR_DATA}};

  // Only the low 4 KB of PADDR is decoded
  logic unused_paddr_hi;
  assign unused_paddr_hi = ^PADDR[31:12];

  // Address decode of the live setup-phase address
  logic                dec_match_d;
  logic [NUM_REGS-1:0] dec_sel_d;
  logic [IDX_W-1:0]    dec_idx_d;

  apb_addr_decode #(
    .NUM_REGS    (NUM_REGS),
    .DATA_W      (DATA_W),
    .ADDR_OFFSET (ADDR_OFFSET),
    .IDX_W       (IDX_W)
  ) u_decode (
    .addr_i  (PADDR[11:0]),
    .match_o (dec_match_d),
    .sel_o   (dec_sel_d),
    .idx_o   (dec_idx_d)
  );

  // Unmapped address or an access against the register's permission
  logic setup_err_d;
  assign setup_err_d = !dec_match_d
                     || ( PWRITE && RO_MASK[dec_idx_d])
                     || (!PWRITE && WO_MASK[dec_idx_d]);

  apb_state_t              state_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    write_q;
  logic [DATA_W-1:0]       w_data_q;
  logic [DATA_W/8-1:0]     w_strb_q;
  logic [NUM_REGS-1:0]     w_enable_q;
  logic [NUM_REGS-1:0]     r_enable_q;
  logic [WC_W-1:0]         wait_cnt_q;
  logic [DATA_W-1:0]       prdata_q;
  logic                    pready_q;
  logic                    pslverr_q;

  // Outputs are updated together with the state they belong to, so each
  // state's output values are visible in exactly the cycles spent in it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      write_q    <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      w_enable_q <= '0;
      r_enable_q <= '0;
      wait_cnt_q <= '0;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Only a genuine setup phase starts a transfer; PSEL with PENABLE
          // already high here is a master protocol violation and is ignored.
          if (PSEL && !PENABLE) begin
            idx_q      <= dec_idx_d;
            write_q    <= PWRITE;
            w_data_q   <= PWDATA;
            w_strb_q   <= PSTRB;
            wait_cnt_q <= '0;
            if (setup_err_d) begin
              state_q   <= ERROR;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
              prdata_q  <= ERR_WORD;
            end else begin
              state_q <= ACCESS;
              if (PWRITE) begin
                // An all-zero strobe write touches no bytes: no enable at all
                if (PSTRB != '0) begin
                  w_enable_q <= dec_sel_d;
                end
              end else begin
                r_enable_q <= dec_sel_d;
              end
            end
          end
        end

        ACCESS: begin
          if (!PSEL) begin
            // Master abandoned the transfer: drop back without PREADY
            state_q    <= IDLE;
            w_enable_q <= '0;
            r_enable_q <= '0;
          end else if (write_q && (w_strb_q == '0)) begin
            state_q  <= DONE;
            pready_q <= 1'b1;
            prdata_q <= '0;
          end else if (reg_ready) begin
            state_q    <= DONE;
            w_enable_q <= '0;
            r_enable_q <= '0;
            pready_q   <= 1'b1;
            prdata_q   <= write_q ? '0 : read_data[idx_q];
          end else if (wait_cnt_q == WC_W'(MAX_WAIT - 1)) begin
            // MAX_WAIT consecutive cycles without acknowledge
            state_q    <= ERROR;
            w_enable_q <= '0;
            r_enable_q <= '0;
            pready_q   <= 1'b1;
            pslverr_q  <= 1'b1;
            prdata_q   <= ERR_WORD;
          end else begin
            wait_cnt_q <= wait_cnt_q + WC_W'(1);
          end
        end

        DONE, ERROR: begin
          // Single completion cycle; next setup is accepted in the IDLE that follows
          state_q   <= IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign PRDATA   = prdata_q;
  assign PREADY   = pready_q;
  assign PSLVERR  = pslverr_q;
  assign w_enable = w_enable_q;
  assign r_enable = r_enable_q;
  assign w_data   = w_data_q;
  assign w_strb   = w_strb_q;

endmodule
